// File: rtl/adc_packet_tagger.sv
// ADC packet tagger: frames a 64-bit sample stream into packets, each preceded
// by a timestamp tag word carrying the sample index of the packet's first sample.
module adc_packet_tagger #(
  parameter logic [6:0] TAG_TYPE_TIME = 7'h01,
  parameter int         LEN_W         = 16
) (
  input  logic             adc_clk,
  input  logic             adc_rst,
  input  logic             enable,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             m_tag_valid,
  output logic [6:0]       m_tag_type,
  output logic             m_last,
  output logic [63:0]      sample_count,
  output logic [31:0]      pkt_count
);

  typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             m_valid_q, m_valid_d;
  logic [63:0]      m_data_q, m_data_d;
  logic             m_tag_valid_q, m_tag_valid_d;
  logic [6:0]       m_tag_type_q, m_tag_type_d;
  logic             m_last_q, m_last_d;
  logic [63:0]      sample_count_q, sample_count_d;
  logic [31:0]      pkt_count_q, pkt_count_d;

  logic             out_free;
  logic             accept;
  logic [LEN_W-1:0] eff_len;

  assign out_free = !m_valid_q || m_ready;
  assign s_ready  = (state_q == DATA) && out_free;
  assign accept   = s_valid && s_ready;
  assign eff_len  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    rem_d          = rem_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_tag_valid_d  = m_tag_valid_q;
    m_tag_type_d   = m_tag_type_q;
    m_last_d       = m_last_q;
    sample_count_d = sample_count_q;
    pkt_count_d    = pkt_count_q;

    // Drain first; a load in the same cycle overrides it and keeps m_valid high.
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && s_valid && out_free) begin
          state_d = TAG;
          len_d   = eff_len;
          rem_d   = eff_len;
        end
      end
      TAG: begin
        // Entry from IDLE guarantees the output register is empty here.
        m_valid_d     = 1'b1;
        m_data_d      = sample_count_q;
        m_tag_valid_d = 1'b1;
        m_tag_type_d  = TAG_TYPE_TIME;
        m_last_d      = 1'b0;
        state_d       = DATA;
      end
      DATA: begin
        if (accept) begin
          m_valid_d      = 1'b1;
          m_data_d       = s_data;
          m_tag_valid_d  = 1'b0;
          m_tag_type_d   = 7'd0;
          m_last_d       = (rem_q == LEN_W'(1));
          sample_count_d = sample_count_q + 64'd1;
          rem_d          = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d     = IDLE;
            pkt_count_d = pkt_count_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      rem_q          <= '0;
      m_valid_q      <= 1'b0;
      m_data_q       <= 64'd0;
      m_tag_valid_q  <= 1'b0;
      m_tag_type_q   <= 7'd0;
      m_last_q       <= 1'b0;
      sample_count_q <= 64'd0;
      pkt_count_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      rem_q          <= rem_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_tag_valid_q  <= m_tag_valid_d;
      m_tag_type_q   <= m_tag_type_d;
      m_last_q       <= m_last_d;
      sample_count_q <= sample_count_d;
      pkt_count_q    <= pkt_count_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_tag_valid  = m_tag_valid_q;
  assign m_tag_type   = m_tag_type_q;
  assign m_last       = m_last_q;
  assign sample_count = sample_count_q;
  assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_adc_packet_tagger.sv
// Directed testbench for adc_packet_tagger: per-scenario tasks with
// hand-computed expected word sequences and counter values.
module tb_adc_packet_tagger;

  logic        adc_clk = 1'b0;
  logic        adc_rst;
  logic        enable;
  logic [15:0] pkt_len;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_tag_valid;
  logic [6:0]  m_tag_type;
  logic        m_last;
  logic [63:0] sample_count;
  logic [31:0] pkt_count;

  always #5 adc_clk = ~adc_clk;

  adc_packet_tagger #(.TAG_TYPE_TIME(7'h01), .LEN_W(16)) dut (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .enable(enable), .pkt_len(pkt_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_tag_valid(m_tag_valid), .m_tag_type(m_tag_type), .m_last(m_last),
    .sample_count(sample_count), .pkt_count(pkt_count)
  );

  typedef struct packed {
    logic        tv;
    logic [6:0]  ty;
    logic        last;
    logic [63:0] d;
  } word_t;

  word_t obs_q[$];
  int    obs_cyc[$];
  int    cyc = 0;
  int    in_cnt;
  int    stall_err;
  word_t held;
  logic  held_v;
  int    tests_run = 0;
  int    tests_failed = 0;

  always @(posedge adc_clk) cyc <= cyc + 1;

  function automatic word_t mk(input bit tv, input logic [63:0] d, input bit last);
    word_t w;
    w.tv   = tv;
    w.ty   = tv ? 7'h01 : 7'h00;
    w.last = last;
    w.d    = d;
    return w;
  endfunction

  // Per cycle: sample outputs on the falling edge, then update stimulus just after the rising edge.
  task automatic run_cycles(input int n, input bit rnd, input int drop_after,
                            input int chg_after, input logic [15:0] new_len);
    bit    acc_in;
    word_t cur;
    for (int i = 0; i < n; i++) begin
      @(negedge adc_clk);
      cur = {m_tag_valid, m_tag_type, m_last, m_data};
      if (held_v && (!m_valid || cur !== held)) stall_err++;
      held_v = m_valid && !m_ready;
      held   = cur;
      if (m_valid && m_ready) begin
        obs_q.push_back(cur);
        obs_cyc.push_back(cyc);
      end
      acc_in = s_valid && s_ready;
      @(posedge adc_clk);
      #1;
      if (acc_in) begin
        in_cnt++;
        s_data = s_data + 64'd1;
        if (in_cnt == drop_after) enable = 1'b0;
        if (in_cnt == chg_after) pkt_len = new_len;
      end
      if (rnd) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    adc_rst = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    pkt_len = 16'd4;
    s_data  = 64'd0;
    repeat (2) @(posedge adc_clk);
    #1;
    adc_rst = 1'b0;
    obs_q.delete();
    obs_cyc.delete();
    in_cnt    = 0;
    held_v    = 1'b0;
    stall_err = 0;
  endtask

  task automatic test_reset();
    adc_rst = 1'b1;
    enable  = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    pkt_len = 16'd4;
    s_data  = 64'h1234;
    repeat (2) @(posedge adc_clk);
    #1;
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
    tests_run++; if (m_data !== 64'd0) begin tests_failed++; $display("FAIL rst_m_data: got %h expected 0", m_data); end
    tests_run++; if (m_tag_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_m_tag_valid: got %b expected 0", m_tag_valid); end
    tests_run++; if (m_tag_type !== 7'd0) begin tests_failed++; $display("FAIL rst_m_tag_type: got %h expected 0", m_tag_type); end
    tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL rst_m_last: got %b expected 0", m_last); end
    tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
    tests_run++; if (sample_count !== 64'd0) begin tests_failed++; $display("FAIL rst_sample_count: got %h expected 0", sample_count); end
    tests_run++; if (pkt_count !== 32'd0) begin tests_failed++; $display("FAIL rst_pkt_count: got %h expected 0", pkt_count); end
    adc_rst = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic test_basic();
    word_t exp_q[$];
    word_t got;
    do_reset();
    pkt_len = 16'd4; s_data = 64'h10; s_valid = 1'b1; enable = 1'b1;
    run_cycles(40, 1'b0, 8, -1, 16'd0);
    exp_q = '{mk(1, 64'd0, 0), mk(0, 64'h10, 0), mk(0, 64'h11, 0), mk(0, 64'h12, 0), mk(0, 64'h13, 1),
              mk(1, 64'd4, 0), mk(0, 64'h14, 0), mk(0, 64'h15, 0), mk(0, 64'h16, 0), mk(0, 64'h17, 1)};
    tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL basic_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL basic_word%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    tests_run++; if (obs_q.size() >= 5 && obs_cyc[4] - obs_cyc[1] != 3) begin tests_failed++; $display("FAIL basic_throughput: got span %0d expected 3", obs_cyc[4] - obs_cyc[1]); end
    tests_run++; if (pkt_count !== 32'd2) begin tests_failed++; $display("FAIL basic_pkt_count: got %0d expected 2", pkt_count); end
    tests_run++; if (sample_count !== 64'd8) begin tests_failed++; $display("FAIL basic_sample_count: got %0d expected 8", sample_count); end
    tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_s_ready: got %b expected 0", s_ready); end
  endtask

  task automatic test_len0();
    word_t exp_q[$];
    word_t got;
    do_reset();
    pkt_len = 16'd0; s_data = 64'hA0; s_valid = 1'b1; enable = 1'b1;
    run_cycles(40, 1'b0, 3, -1, 16'd0);
    exp_q = '{mk(1, 64'd0, 0), mk(0, 64'hA0, 1), mk(1, 64'd1, 0), mk(0, 64'hA1, 1),
              mk(1, 64'd2, 0), mk(0, 64'hA2, 1)};
    tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL len0_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL len0_word%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    tests_run++; if (pkt_count !== 32'd3) begin tests_failed++; $display("FAIL len0_pkt_count: got %0d expected 3", pkt_count); end
  endtask

  task automatic test_backpressure();
    word_t exp_q[$];
    word_t got;
    do_reset();
    pkt_len = 16'd3; s_data = 64'h200; s_valid = 1'b1; enable = 1'b1;
    run_cycles(200, 1'b1, 9, -1, 16'd0);
    m_ready = 1'b1;
    run_cycles(20, 1'b0, -1, -1, 16'd0);
    exp_q = '{mk(1, 64'd0, 0), mk(0, 64'h200, 0), mk(0, 64'h201, 0), mk(0, 64'h202, 1),
              mk(1, 64'd3, 0), mk(0, 64'h203, 0), mk(0, 64'h204, 0), mk(0, 64'h205, 1),
              mk(1, 64'd6, 0), mk(0, 64'h206, 0), mk(0, 64'h207, 0), mk(0, 64'h208, 1)};
    tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL bp_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL bp_word%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    tests_run++; if (stall_err != 0) begin tests_failed++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_err); end
    tests_run++; if (pkt_count !== 32'd3) begin tests_failed++; $display("FAIL bp_pkt_count: got %0d expected 3", pkt_count); end
  endtask

  task automatic test_enable_drop();
    word_t exp_q[$];
    word_t got;
    do_reset();
    pkt_len = 16'd8; s_data = 64'h300; s_valid = 1'b1; enable = 1'b1;
    run_cycles(40, 1'b0, 2, 1, 16'd2);
    exp_q = '{mk(1, 64'd0, 0)};
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(0, 64'h300 + 64'(k), k == 7));
    tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL endrop_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL endrop_word%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL endrop_s_ready: got %b expected 0", s_ready); end
    tests_run++; if (pkt_count !== 32'd1) begin tests_failed++; $display("FAIL endrop_pkt_count: got %0d expected 1", pkt_count); end
    tests_run++; if (sample_count !== 64'd8) begin tests_failed++; $display("FAIL endrop_sample_count: got %0d expected 8", sample_count); end
  endtask

  task automatic test_reset_mid();
    word_t exp_q[$];
    word_t got;
    do_reset();
    pkt_len = 16'd4; s_data = 64'h400; s_valid = 1'b1; enable = 1'b1;
    run_cycles(4, 1'b0, -1, -1, 16'd0);
    m_ready = 1'b0;
    @(negedge adc_clk);
    tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre_valid: got %b expected 1", m_valid); end
    adc_rst = 1'b1;
    @(posedge adc_clk);
    #1;
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_m_valid: got %b expected 0", m_valid); end
    tests_run++; if (sample_count !== 64'd0) begin tests_failed++; $display("FAIL rmid_sample_count: got %0d expected 0", sample_count); end
    tests_run++; if (pkt_count !== 32'd0) begin tests_failed++; $display("FAIL rmid_pkt_count: got %0d expected 0", pkt_count); end
    adc_rst = 1'b0;
    m_ready = 1'b1;
    s_data  = 64'h500;
    obs_q.delete(); obs_cyc.delete(); in_cnt = 0; held_v = 1'b0; stall_err = 0;
    run_cycles(20, 1'b0, 1, -1, 16'd0);
    exp_q = '{mk(1, 64'd0, 0), mk(0, 64'h500, 0), mk(0, 64'h501, 0), mk(0, 64'h502, 0), mk(0, 64'h503, 1)};
    tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rmid_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL rmid_word%0d: got %h expected %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    word_t exp_q[$];
    word_t got;
    do_reset();
    @(negedge adc_clk);
    force dut.sample_count_q = 64'hFFFF_FFFF_FFFF_FFFE;
    force dut.pkt_count_q    = 32'hFFFF_FFFF;
    @(posedge adc_clk);
    @(negedge adc_clk);
    release dut.sample_count_q;
    release dut.pkt_count_q;
    #1;
    tests_run++; if (sample_count !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL wrap_preset_sc: got %h expected fffffffffffffffe", sample_count); end
    tests_run++; if (pkt_count !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL wrap_preset_pc: got %h expected ffffffff", pkt_count); end
    pkt_len = 16'd4; s_data = 64'h600; s_valid = 1'b1; enable = 1'b1;
    run_cycles(40, 1'b0, 8, -1, 16'd0);
    exp_q = '{mk(1, 64'hFFFF_FFFF_FFFF_FFFE, 0), mk(0, 64'h600, 0), mk(0, 64'h601, 0), mk(0, 64'h602, 0), mk(0, 64'h603, 1),
              mk(1, 64'd2, 0), mk(0, 64'h604, 0), mk(0, 64'h605, 0), mk(0, 64'h606, 0), mk(0, 64'h607, 1)};
    tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL wrap_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL wrap_word%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    tests_run++; if (sample_count !== 64'd6) begin tests_failed++; $display("FAIL wrap_sample_count: got %h expected 6", sample_count); end
    tests_run++; if (pkt_count !== 32'd1) begin tests_failed++; $display("FAIL wrap_pkt_count: got %h expected 1", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
